seq_detect_ctrl: RTL

SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

---
 rtl/seq_detect_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/seq_detect_ctrl.sv
// ---------------------------------------------------------------------------------------------
// seq_detect_ctrl
//
// Purpose:
//   Watches a serial bit stream for runs of consecutive 1s. A run of detection is started with
//   i_start, samples i_x once per cycle while busy, and ends either after a programmed number
//   of samples (normal completion, o_done pulse) or when i_abort is raised (no o_done pulse).
//   o_hit is high while the current run of 1s has reached the captured threshold, and
//   o_hit_count counts how many distinct runs of 1s reached the threshold.
//
// Configuration:
//   SEQ_DETECT_CTRL_COUNT_EN - when defined, the hit counter is built. When undefined,
//                              o_hit_count is tied to 0 and no counter register exists.
//
// Parameters:
//   CW           - width of i_window and o_hit_count.
//
// Ports:
//   i_clk        - clock, all state updates on the rising edge.
//   i_rst        - asynchronous active-high reset.
//   i_start      - request a detection run (only honoured while idle).
//   i_abort      - terminate a run in progress without a done pulse.
//   i_x          - serial bit stream, sampled once per running cycle.
//   i_thresh     - required count of consecutive 1s, captured at start (0 acts as 1).
//   i_window     - run length in samples, captured at start (0 = run until abort).
//   o_busy       - high while a run is in progress.
//   o_hit        - high while the current run of 1s is at least the threshold.
//   o_done       - single-cycle pulse on normal run completion.
//   o_hit_count  - number of runs of 1s that reached the threshold in the last/current run.
// ---------------------------------------------------------------------------------------------
module seq_detect_ctrl #(
    parameter int unsigned CW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic          i_x,
    input  logic [3:0]    i_thresh,
    input  logic [CW-1:0] i_window,
    output logic          o_busy,
    output logic          o_hit,
    output logic          o_done,
    output logic [CW-1:0] o_hit_count
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e        r_state;
    state_e        w_state_d;

    logic [3:0]    r_run_len;
    logic [3:0]    w_run_len_d;
    logic [3:0]    r_thr;
    logic [3:0]    w_thr_d;
    logic [CW-1:0] r_cyc_cnt;
    logic [CW-1:0] w_cyc_cnt_d;
    logic [CW-1:0] r_win;
    logic [CW-1:0] w_win_d;

    logic          r_busy;
    logic          r_hit;
    logic          r_done;
    logic          w_busy_d;
    logic          w_hit_d;
    logic          w_done_d;

    logic [3:0]    w_run_len_inc;
    logic [CW-1:0] w_cyc_inc;
    logic          w_win_end;
    logic          w_accept;

    // Run length saturates at 15 so a long run of 1s never wraps back below the threshold.
    assign w_run_len_inc = (r_run_len == 4'd15) ? 4'd15 : (r_run_len + 4'd1);
    assign w_cyc_inc     = r_cyc_cnt + CW'(1);
    // A zero window means unbounded: the sample counter is allowed to wrap freely.
    assign w_win_end     = (r_win != '0) && (w_cyc_inc == r_win);
    assign w_accept      = (r_state == StIdle) && i_start;

    // -----------------------------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_run_len <= 4'd0;
            r_thr     <= 4'd0;
            r_cyc_cnt <= '0;
            r_win     <= '0;
            r_busy    <= 1'b0;
            r_hit     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_run_len <= w_run_len_d;
            r_thr     <= w_thr_d;
            r_cyc_cnt <= w_cyc_cnt_d;
            r_win     <= w_win_d;
            r_busy    <= w_busy_d;
            r_hit     <= w_hit_d;
            r_done    <= w_done_d;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------------------------
    always_comb begin
        w_state_d   = r_state;
        w_run_len_d = r_run_len;
        w_thr_d     = r_thr;
        w_cyc_cnt_d = r_cyc_cnt;
        w_win_d     = r_win;

        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_d   = StRun;
                    // A threshold of zero would make hit permanently true; treat it as one.
                    w_thr_d     = (i_thresh == 4'd0) ? 4'd1 : i_thresh;
                    w_win_d     = i_window;
                    w_run_len_d = 4'd0;
                    w_cyc_cnt_d = '0;
                end
            end
            StRun: begin
                // Abort wins over window completion on the same edge.
                if (i_abort) begin
                    w_state_d = StIdle;
                end else begin
                    w_run_len_d = i_x ? w_run_len_inc : 4'd0;
                    w_cyc_cnt_d = w_cyc_inc;
                    if (w_win_end) begin
                        w_state_d = StDone;
                    end
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // -----------------------------------------------------------------------------------------
    // Output logic: computed from the next state so every output is a plain register.
    // -----------------------------------------------------------------------------------------
    always_comb begin
        w_busy_d = (w_state_d == StRun);
        w_hit_d  = (w_state_d == StRun) && (w_run_len_d >= w_thr_d);
        w_done_d = (w_state_d == StDone);
    end

    assign o_busy = r_busy;
    assign o_hit  = r_hit;
    assign o_done = r_done;

`ifdef SEQ_DETECT_CTRL_COUNT_EN
    logic [CW-1:0] r_hit_count;
    logic [CW-1:0] w_hit_count_d;
    logic          w_cross;

    // Counts only the edge where the run length steps from thr-1 to thr, so one long run of
    // 1s is counted once. An aborting edge does not update the run, so it cannot count.
    assign w_cross = (r_state == StRun) && !i_abort && i_x && (r_run_len == (r_thr - 4'd1));

    always_comb begin
        w_hit_count_d = r_hit_count;
        if (w_accept) begin
            w_hit_count_d = '0;
        end else if (w_cross && (r_hit_count != '1)) begin
            w_hit_count_d = r_hit_count + CW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hit_count <= '0;
        end else begin
            r_hit_count <= w_hit_count_d;
        end
    end

    assign o_hit_count = r_hit_count;
`else
    // Counter not built; the start-accept term is only needed by the counter.
    logic w_unused;
    assign w_unused    = w_accept;
    assign o_hit_count = '0;
`endif

endmodule
